// File: rtl/ex_mem_pkg.sv
// Shared types for the Execute->Memory pipeline stage: control bundle layout and widths.
package ex_mem_pkg;

  localparam int unsigned CTRL_W = 7;

  // Bit positions of each control flag within the flat 7-bit control bus.
  localparam int unsigned CTRL_BIT_WBS  = 6;
  localparam int unsigned CTRL_BIT_MM   = 5;
  localparam int unsigned CTRL_BIT_WM   = 4;
  localparam int unsigned CTRL_BIT_NI   = 3;
  localparam int unsigned CTRL_BIT_WCE  = 2;
  localparam int unsigned CTRL_BIT_WME1 = 1;
  localparam int unsigned CTRL_BIT_WME2 = 0;

  typedef struct packed {
    logic wbs;
    logic mm;
    logic wm;
    logic ni;
    logic wce;
    logic wme1;
    logic wme2;
  } ctrl_t;

  // An invalid slot must look like a NOP to MEM, so its control is forced to zero.
  function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t ctrl);
    return valid ? ctrl : ctrl_t'('0);
  endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// Execute->Memory pipeline register with a 2-entry skid buffer and flush.
// Optional stall-cycle counter enabled by defining EXMEM_STALL_CNT_EN.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    ctrl_t             ctrl;
  } slot_t;

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("ex_mem_stage: DATA_W and CNT_W must be at least 1");
  end

  slot_t main_q;
  slot_t skid_q;
  slot_t in_slot;
  logic  main_valid_q;
  logic  skid_valid_q;
  logic  accept;
  logic  fire;
  logic  main_free;

  always_comb begin
    in_slot            = '0;
    in_slot.alu_result = in_alu_result;
    in_slot.mem_data   = in_mem_data;
    in_slot.ctrl.wbs   = in_ctrl[CTRL_BIT_WBS];
    in_slot.ctrl.mm    = in_ctrl[CTRL_BIT_MM];
    in_slot.ctrl.wm    = in_ctrl[CTRL_BIT_WM];
    in_slot.ctrl.ni    = in_ctrl[CTRL_BIT_NI];
    in_slot.ctrl.wce   = in_ctrl[CTRL_BIT_WCE];
    in_slot.ctrl.wme1  = in_ctrl[CTRL_BIT_WME1];
    in_slot.ctrl.wme2  = in_ctrl[CTRL_BIT_WME2];
  end

  // in_ready comes straight from the skid flag so EX never sees MEM's ready combinationally.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign fire      = main_valid_q && out_ready;
  assign main_free = !main_valid_q || fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; only the valid flags are cleared.
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= accept;
        if (accept) begin
          skid_q <= in_slot;
        end
      end else if (accept) begin
        main_q       <= in_slot;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= in_slot;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_alu_result = main_q.alu_result;
  assign out_mem_data   = main_q.mem_data;
  assign out_ctrl       = gate_ctrl(main_valid_q, main_q.ctrl);

`ifdef EXMEM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid_q && !out_ready && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and scoreboard checks for ex_mem_stage (16-bit and 32-bit instances).
module tb_ex_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_alu_result;
  logic [15:0] in_mem_data;
  logic [6:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_alu_result;
  logic [15:0] out_mem_data;
  logic [6:0]  out_ctrl;
`ifdef EXMEM_STALL_CNT_EN
  logic [3:0]  stall_cycles;
  logic [15:0] stall32;
`endif

  logic        flush32;
  logic        iv32;
  logic        ir32;
  logic [31:0] ia32;
  logic [31:0] id32;
  logic [6:0]  ic32;
  logic        ov32;
  logic        or32;
  logic [31:0] oa32;
  logic [31:0] od32;
  logic [6:0]  oc32;

  ex_mem_stage #(.DATA_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_mem_data(out_mem_data), .out_ctrl(out_ctrl)
`ifdef EXMEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  ex_mem_stage #(.DATA_W(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32),
    .in_valid(iv32), .in_ready(ir32),
    .in_alu_result(ia32), .in_mem_data(id32), .in_ctrl(ic32),
    .out_valid(ov32), .out_ready(or32),
    .out_alu_result(oa32), .out_mem_data(od32), .out_ctrl(oc32)
`ifdef EXMEM_STALL_CNT_EN
    , .stall_cycles(stall32)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic [6:0] c);
    in_valid      = v;
    in_alu_result = a;
    in_mem_data   = d;
    in_ctrl       = c;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [6:0]  c;
  } ent_t;

  ent_t exp_q[$];
  ent_t e;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    flush32 = 1'b0; iv32 = 1'b0; ia32 = '0; id32 = '0; ic32 = '0; or32 = 1'b0;

    // 1: reset
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_out_alu", 64'(out_alu_result), 64'd0);
    check("rst_out_data", 64'(out_mem_data), 64'd0);
    rst = 1'b0;

    // 2: pass-through, back-to-back
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'hABCD, 7'b1101000);
    tick();
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_alu", 64'(out_alu_result), 64'h1234);
    check("t2_data", 64'(out_mem_data), 64'hABCD);
    check("t2_ctrl", 64'(out_ctrl), 64'h68);
    drive(1'b1, 16'h4A81, 16'h7755, 7'b0000101);
    tick();
    check("t2_b2b0_alu", 64'(out_alu_result), 64'h4A81);
    check("t2_b2b0_data", 64'(out_mem_data), 64'h7755);
    check("t2_b2b0_ctrl", 64'(out_ctrl), 64'h05);
    drive(1'b1, 16'h7755, 16'h4A81, 7'b0010010);
    tick();
    check("t2_b2b1_alu", 64'(out_alu_result), 64'h7755);
    check("t2_b2b1_valid", 64'(out_valid), 64'd1);
    drive(1'b0, '0, '0, '0);
    tick();
    check("t2_drain_valid", 64'(out_valid), 64'd0);
    check("t2_drain_ctrl", 64'(out_ctrl), 64'd0);

    // 3: back-pressure fills skid, then releases in order
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 16'h1001, 7'b1000000);
    tick();
    check("t3_e1_alu", 64'(out_alu_result), 64'h0001);
    check("t3_e1_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 16'h0002, 16'h1002, 7'b0100000);
    tick();
    check("t3_e2_ready", 64'(in_ready), 64'd0);
    check("t3_e2_hold", 64'(out_alu_result), 64'h0001);
    drive(1'b1, 16'h0003, 16'h1003, 7'b0010000);
    tick();
    check("t3_e3_ready", 64'(in_ready), 64'd0);
    check("t3_e3_hold", 64'(out_alu_result), 64'h0001);
    check("t3_e3_ctrl", 64'(out_ctrl), 64'h40);
    out_ready = 1'b1;
    tick();
    check("t3_rel1_alu", 64'(out_alu_result), 64'h0002);
    check("t3_rel1_valid", 64'(out_valid), 64'd1);
    check("t3_rel1_ready", 64'(in_ready), 64'd1);
    tick();
    check("t3_rel2_alu", 64'(out_alu_result), 64'h0003);
    check("t3_rel2_data", 64'(out_mem_data), 64'h1003);
    check("t3_rel2_valid", 64'(out_valid), 64'd1);
    drive(1'b0, '0, '0, '0);
    tick();
    check("t3_empty", 64'(out_valid), 64'd0);

    // 4: flush with both slots full
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 16'h2011, 7'b1111111);
    tick();
    drive(1'b1, 16'h0022, 16'h2022, 7'b1111111);
    tick();
    drive(1'b1, 16'hDEAD, 16'hDEAD, 7'b1111111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("t4_valid", 64'(out_valid), 64'd0);
    check("t4_ctrl", 64'(out_ctrl), 64'd0);
    check("t4_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_dead", 64'(out_valid), 64'd0);
    end

    // 4b: entry accepted during the flush cycle is discarded
    out_ready = 1'b0;
    drive(1'b1, 16'h0033, 16'h2033, 7'b0000001);
    tick();
    drive(1'b1, 16'hBEEF, 16'hBEEF, 7'b0000011);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("t4b_valid", 64'(out_valid), 64'd0);
    check("t4b_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("t4b_no_beef", 64'(out_valid), 64'd0);

    // rst mid-stall
    out_ready = 1'b0;
    drive(1'b1, 16'h0044, 16'h2044, 7'b0000001);
    tick(); tick();
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();
    rst = 1'b0;
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_ready", 64'(in_ready), 64'd1);
    check("rstmid_alu", 64'(out_alu_result), 64'd0);
    check("rstmid_ctrl", 64'(out_ctrl), 64'd0);

`ifdef EXMEM_STALL_CNT_EN
    // 5: saturating stall counter
    check("t5_zero", 64'(stall_cycles), 64'd0);
    drive(1'b1, 16'h0055, 16'h2055, 7'b0000001);
    tick();
    drive(1'b0, '0, '0, '0);
    check("t5_start", 64'(stall_cycles), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    check("t5_sat", 64'(stall_cycles), 64'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush", 64'(stall_cycles), 64'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst", 64'(stall_cycles), 64'd0);
`endif

    // 6: 32-bit instance, directed then random scoreboard
    or32 = 1'b1;
    iv32 = 1'b1; ia32 = 32'hCAFEBABE; id32 = 32'h8BADF00D; ic32 = 7'b1010101;
    tick();
    iv32 = 1'b0;
    check("t6_alu", 64'(oa32), 64'hCAFEBABE);
    check("t6_data", 64'(od32), 64'h8BADF00D);
    check("t6_ctrl", 64'(oc32), 64'h55);
    tick();

    begin
      int unsigned sent = 0;
      int unsigned got  = 0;
      int unsigned cyc  = 0;
      while (got < 1000 && cyc < 20000) begin
        iv32 = (sent < 1000) && ($urandom_range(0, 3) != 0);
        ia32 = $urandom;
        id32 = $urandom;
        ic32 = 7'($urandom);
        or32 = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (!ov32) check("t6_bubble_ctrl", 64'(oc32), 64'd0);
        if (ov32 && or32) begin
          if (exp_q.size() == 0) begin
            check("t6_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("t6_sb_entry", {oa32, od32} ^ 64'(oc32), {e.a, e.d} ^ 64'(e.c));
          end
          got++;
        end
        if (iv32 && ir32) begin
          exp_q.push_back('{a: ia32, d: id32, c: ic32});
          sent++;
        end
        tick();
        cyc++;
      end
      check("t6_sb_done", 64'(got), 64'd1000);
      check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
